// File: rtl/control_pkg.sv
// Shared types and constants for the instruction sequencer: FSM states,
// opcodes, ALU function selects and register-file write-source selects.
package control_pkg;

    typedef enum logic [3:0] {
        S_INIT,
        S_FETCH,
        S_DECODE,
        S_NOOP,
        S_STORE,
        S_LOAD_A,
        S_LOAD_B,
        S_ALU,
        S_LOADC,
        S_JMPZ_A,
        S_JMPZ_B,
        S_HALT
    } state_t;

    typedef enum logic [3:0] {
        OP_NOOP  = 4'h0,
        OP_STORE = 4'h1,
        OP_LOAD  = 4'h2,
        OP_ADD   = 4'h3,
        OP_SUB   = 4'h4,
        OP_LOADC = 4'h5,
        OP_JMPZ  = 4'h6,
        OP_HALT  = 4'h7,
        OP_XOR   = 4'h8,
        OP_OR    = 4'h9,
        OP_AND   = 4'hA,
        OP_INC   = 4'hB
    } opcode_t;

    localparam logic [2:0] ALU_ZERO   = 3'd0;
    localparam logic [2:0] ALU_ADD    = 3'd1;
    localparam logic [2:0] ALU_SUB    = 3'd2;
    localparam logic [2:0] ALU_PASS_A = 3'd3;
    localparam logic [2:0] ALU_XOR    = 3'd4;
    localparam logic [2:0] ALU_OR     = 3'd5;
    localparam logic [2:0] ALU_AND    = 3'd6;
    localparam logic [2:0] ALU_INC    = 3'd7;

    localparam logic [1:0] RF_SRC_ALU   = 2'd0;
    localparam logic [1:0] RF_SRC_MEM   = 2'd1;
    localparam logic [1:0] RF_SRC_CONST = 2'd2;

    function automatic logic [2:0] alu_sel_for(input logic [3:0] op);
        case (op)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_XOR:  return ALU_XOR;
            OP_OR:   return ALU_OR;
            OP_AND:  return ALU_AND;
            OP_INC:  return ALU_INC;
            default: return ALU_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/control_unit_pc_counter.sv
// Program counter: synchronous clear, increment, or add a sign-extended
// 8-bit offset; all updates wrap modulo 2**PC_W.
module pc_counter #(
    parameter int PC_W = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr_i,
    input  logic            inc_i,
    input  logic            load_rel_i,
    input  logic [7:0]      offset_i,
    output logic [PC_W-1:0] pc_o
);

    // Add at the wider of PC_W and 8 so the offset sign-extends before truncation.
    localparam int EW = (PC_W > 8) ? PC_W : 8;

    logic [PC_W-1:0] pc_q, pc_d;
    logic [EW-1:0]   rel_sum;

    assign rel_sum = EW'(pc_q) + EW'($signed(offset_i));

    always_comb begin
        pc_d = pc_q;
        if (clr_i) begin
            pc_d = '0;
        end else if (load_rel_i) begin
            pc_d = rel_sum[PC_W-1:0];
        end else if (inc_i) begin
            pc_d = pc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/control_unit.sv
// Instruction sequencer: fetch/decode/execute FSM plus IR. All datapath
// commands are Moore outputs of the registered state and IR.
module control_unit
    import control_pkg::*;
#(
    parameter int PC_W = 7
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [15:0]     ir_data,
    input  logic            zero_flag,
    output logic [PC_W-1:0] pc,
    output logic            im_rd,
    output logic [7:0]      d_addr,
    output logic            d_rd,
    output logic            d_wr,
    output logic [3:0]      rf_ra_addr,
    output logic [3:0]      rf_rb_addr,
    output logic [3:0]      rf_w_addr,
    output logic            rf_w_en,
    output logic [1:0]      rf_src,
    output logic [7:0]      rf_const,
    output logic [2:0]      alu_sel,
    output logic            halted,
    output logic [3:0]      dbg_state
);

    state_t      state_q, state_d;
    logic [15:0] ir_q;

    logic [3:0]  op;
    logic [3:0]  f_hi, f_mid, f_lo;
    logic [7:0]  f_byte;

    assign op     = ir_q[15:12];
    assign f_hi   = ir_q[11:8];
    assign f_mid  = ir_q[7:4];
    assign f_lo   = ir_q[3:0];
    assign f_byte = ir_q[7:0];

    // Branch offset comes from the IR latched in DECODE; PC was already bumped there.
    pc_counter #(.PC_W(PC_W)) u_pc (
        .clk        (clk),
        .rst        (reset),
        .clr_i      (state_q == S_INIT),
        .inc_i      (state_q == S_DECODE),
        .load_rel_i ((state_q == S_JMPZ_B) && zero_flag),
        .offset_i   (f_byte),
        .pc_o       (pc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_INIT;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                ir_q <= ir_data;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:   state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (ir_data[15:12])
                    OP_STORE: state_d = S_STORE;
                    OP_LOAD:  state_d = S_LOAD_A;
                    OP_ADD, OP_SUB, OP_XOR, OP_OR, OP_AND, OP_INC:
                              state_d = S_ALU;
                    OP_LOADC: state_d = S_LOADC;
                    OP_JMPZ:  state_d = S_JMPZ_A;
                    OP_HALT:  state_d = S_HALT;
                    default:  state_d = S_NOOP;
                endcase
            end
            S_LOAD_A: state_d = S_LOAD_B;
            S_JMPZ_A: state_d = S_JMPZ_B;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        im_rd      = 1'b0;
        d_addr     = '0;
        d_rd       = 1'b0;
        d_wr       = 1'b0;
        rf_ra_addr = '0;
        rf_rb_addr = '0;
        rf_w_addr  = '0;
        rf_w_en    = 1'b0;
        rf_src     = RF_SRC_ALU;
        rf_const   = '0;
        alu_sel    = ALU_ZERO;
        halted     = 1'b0;
        case (state_q)
            S_FETCH: im_rd = 1'b1;
            S_STORE: begin
                rf_ra_addr = f_hi;
                alu_sel    = ALU_PASS_A;
                d_addr     = f_byte;
                d_wr       = 1'b1;
            end
            S_LOAD_A: begin
                d_addr = f_byte;
                d_rd   = 1'b1;
            end
            S_LOAD_B: begin
                d_addr    = f_byte;
                rf_src    = RF_SRC_MEM;
                rf_w_addr = f_hi;
                rf_w_en   = 1'b1;
            end
            S_ALU: begin
                rf_ra_addr = f_hi;
                rf_rb_addr = (op == OP_INC) ? 4'd0 : f_mid;
                alu_sel    = alu_sel_for(op);
                rf_src     = RF_SRC_ALU;
                rf_w_addr  = f_lo;
                rf_w_en    = 1'b1;
            end
            S_LOADC: begin
                rf_src    = RF_SRC_CONST;
                rf_const  = f_byte;
                rf_w_addr = f_hi;
                rf_w_en   = 1'b1;
            end
            S_JMPZ_A: begin
                rf_ra_addr = f_hi;
                alu_sel    = ALU_PASS_A;
            end
            S_HALT: halted = 1'b1;
            default: ;
        endcase
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: instruction memory and a zero-flag stub react to the
// DUT; a program-level model predicts every output event with its cycle stamp.
module tb_control_unit;
    import control_pkg::*;

    localparam int PC_W = 7;
    localparam int EV_W = 61;

    logic            clk, reset;
    logic [15:0]     ir_data;
    logic            zero_flag;
    logic [PC_W-1:0] pc;
    logic            im_rd, d_rd, d_wr, rf_w_en, halted;
    logic [7:0]      d_addr, rf_const;
    logic [3:0]      rf_ra_addr, rf_rb_addr, rf_w_addr, dbg_state;
    logic [1:0]      rf_src;
    logic [2:0]      alu_sel;

    control_unit #(.PC_W(PC_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .ir_data    (ir_data),
        .zero_flag  (zero_flag),
        .pc         (pc),
        .im_rd      (im_rd),
        .d_addr     (d_addr),
        .d_rd       (d_rd),
        .d_wr       (d_wr),
        .rf_ra_addr (rf_ra_addr),
        .rf_rb_addr (rf_rb_addr),
        .rf_w_addr  (rf_w_addr),
        .rf_w_en    (rf_w_en),
        .rf_src     (rf_src),
        .rf_const   (rf_const),
        .alu_sel    (alu_sel),
        .halted     (halted),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // ---------------- environment ----------------
    logic [15:0]     imem [128];
    bit              zmask [16];
    logic [EV_W-1:0] exp_q [$];
    int              n_cmp = 0;
    int              n_bad = 0;

    // Registered instruction memory and a zero flag that follows the register read.
    initial begin
        logic [15:0] nxt_ir;
        logic        nxt_zf;
        forever begin
            @(negedge clk);
            nxt_ir = im_rd ? imem[pc] : ir_data;
            nxt_zf = zmask[rf_ra_addr];
            @(posedge clk);
            #1;
            ir_data   = nxt_ir;
            zero_flag = nxt_zf;
        end
    end

    function automatic logic [EV_W-1:0] mk_ev(int c, int p, bit ird, bit drd, bit dwr, int da,
                                              bit wen, int src, int wa, int ra, int rb,
                                              int sel, int k, bit h);
        return {16'(c), 7'(p), ird, drd, dwr, 8'(da), wen, 2'(src), 4'(wa), 4'(ra), 4'(rb),
                3'(sel), 8'(k), h};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Walks the program instruction by instruction and queues every visible
    // output event with the cycle (counted from reset release) it must occur in.
    task automatic run_model(input int max_instr);
        int p = 0;
        int f = 1;
        int sel_of [16] = '{0, 0, 0, 1, 2, 0, 0, 0, 4, 5, 6, 7, 0, 0, 0, 0};
        for (int n = 0; n < max_instr; n++) begin
            logic [15:0] w;
            int op, hi, mid, lo, b, off;
            w   = imem[p];
            op  = int'(w[15:12]);
            hi  = int'(w[11:8]);
            mid = int'(w[7:4]);
            lo  = int'(w[3:0]);
            b   = int'(w[7:0]);
            exp_q.push_back(mk_ev(f, p, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            p = (p + 1) % 128;
            case (op)
                1: begin
                    exp_q.push_back(mk_ev(f + 2, p, 0, 0, 1, b, 0, 0, 0, hi, 0, 3, 0, 0));
                    f += 3;
                end
                2: begin
                    exp_q.push_back(mk_ev(f + 2, p, 0, 1, 0, b, 0, 0, 0, 0, 0, 0, 0, 0));
                    exp_q.push_back(mk_ev(f + 3, p, 0, 0, 0, b, 1, 1, hi, 0, 0, 0, 0, 0));
                    f += 4;
                end
                3, 4, 8, 9, 10, 11: begin
                    exp_q.push_back(mk_ev(f + 2, p, 0, 0, 0, 0, 1, 0, lo, hi,
                                          (op == 11) ? 0 : mid, sel_of[op], 0, 0));
                    f += 3;
                end
                5: begin
                    exp_q.push_back(mk_ev(f + 2, p, 0, 0, 0, 0, 1, 2, hi, 0, 0, 0, b, 0));
                    f += 3;
                end
                6: begin
                    exp_q.push_back(mk_ev(f + 2, p, 0, 0, 0, 0, 0, 0, 0, hi, 0, 3, 0, 0));
                    off = (b >= 128) ? b - 256 : b;
                    if (zmask[hi]) p = (p + off + 256) % 128;
                    f += 4;
                end
                7: begin
                    for (int k = 0; k < 20; k++)
                        exp_q.push_back(mk_ev(f + 2 + k, p, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
                    return;
                end
                default: f += 3;
            endcase
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [EV_W-1:0] act, exp;
        if (!reset && exp_q.size() > 0 &&
            (im_rd || d_rd || d_wr || rf_w_en || halted || alu_sel != 3'd0)) begin
            act = {16'(cyc), pc, im_rd, d_rd, d_wr, d_addr, rf_w_en, rf_src, rf_w_addr,
                   rf_ra_addr, rf_rb_addr, alu_sel, rf_const, halted};
            exp = exp_q.pop_front();
            n_cmp++;
            if (act !== exp) begin
                n_bad++;
                $display("FAIL event: got %h expected %h (cyc|pc|strobes|addrs|sel|const|halt)",
                         act, exp);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_prog();
        for (int i = 0; i < 128; i++) imem[i] = 16'h0000;
        for (int i = 0; i < 16; i++) zmask[i] = 1'b0;
    endtask

    task automatic run_prog(input string name, input int max_instr);
        bit drained;
        reset = 1'b1;
        exp_q.delete();
        run_model(max_instr);
        @(negedge clk);
        #2 reset = 1'b0;
        #1 chk({name, "_init"}, int'(dbg_state), int'(S_INIT));
        drained = 1'b0;
        for (int i = 0; i < 3000 && !drained; i++) begin
            @(posedge clk);
            if (exp_q.size() == 0) drained = 1'b1;
        end
        n_cmp++;
        if (!drained) begin
            n_bad++;
            $display("FAIL %s_timeout: got %0d events pending expected 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit seen;
        reset     = 1'b1;
        ir_data   = 16'h0000;
        zero_flag = 1'b0;
        clear_prog();
        #1;
        chk("reset_idle", int'({im_rd, d_rd, d_wr, rf_w_en, halted, d_addr, rf_const,
                                rf_src, alu_sel, rf_ra_addr, rf_rb_addr, rf_w_addr}), 0);
        chk("reset_pc", int'(pc), 0);
        chk("reset_state", int'(dbg_state), int'(S_INIT));
        repeat (2) @(negedge clk);

        // Reset landing inside LOAD_B must drop the write enable immediately.
        imem[0] = 16'h2A40;
        #2 reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (rf_w_en) seen = 1'b1;
        end
        chk("reach_load_b", int'(seen), 1);
        #2 reset = 1'b1;
        #1;
        chk("loadb_reset_wen", int'(rf_w_en), 0);
        chk("loadb_reset_state", int'(dbg_state), int'(S_INIT));

        // Directed program: ADD, LOAD, LOADC, C-F as NOOP, STORE, JMPZ, HALT.
        clear_prog();
        imem[0] = 16'h3123;
        imem[1] = 16'h2A40;
        imem[2] = 16'h5C7F;
        imem[3] = 16'hF123;
        imem[4] = 16'h1455;
        imem[5] = 16'h63FE;
        imem[6] = 16'h7000;
        zmask[3] = 1'b1;
        run_prog("dir_taken", 14);
        zmask[3] = 1'b0;
        run_prog("dir_halt", 20);
        chk("halt_state", int'(dbg_state), int'(S_HALT));

        // Forward jump to the last word, then PC wraps to 0.
        clear_prog();
        imem[0] = 16'h607E;
        run_prog("wrap_nt", 4);
        zmask[0] = 1'b1;
        run_prog("wrap_taken", 6);

        // Offset 0xFF re-executes the branch itself.
        clear_prog();
        imem[0] = 16'h60FF;
        zmask[0] = 1'b1;
        run_prog("self_loop", 4);

        // Random programs and zero-flag patterns.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 128; i++) imem[i] = 16'($urandom_range(0, 65535));
            for (int i = 0; i < 16; i++) zmask[i] = 1'($urandom_range(0, 1));
            run_prog($sformatf("rand%0d", r), 120);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
